// File: rtl/satd_pkg.sv
// Shared constants for the SATD engine scheduler: FSM encoding and engine defaults.
package satd_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam int SATD_W_DFLT  = 16;
  // Nominal diff->HT->HT->abs->sum pipeline depth; watchdog must exceed this.
  localparam int SATD_ENG_LAT = 19;
endpackage

// File: rtl/satd_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after ptr, wrapping around.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] win,
  output logic [ID_W-1:0] win_idx,
  output logic            any
);
  logic [NREQ-1:0][ID_W-1:0] cand;

  // cand[k] = (ptr + k + 1) mod NREQ, so cand[0] has highest priority.
  for (genvar k = 0; k < NREQ; k++) begin : g_cand
    logic [ID_W:0] sum;
    assign sum     = {1'b0, ptr} + (ID_W+1)'(k + 1);
    assign cand[k] = (sum >= (ID_W+1)'(NREQ)) ? ID_W'(sum - (ID_W+1)'(NREQ)) : sum[ID_W-1:0];
  end

  always_comb begin
    win_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req[cand[k]]) win_idx = cand[k];
    any = |req;
    win = any ? ({{(NREQ-1){1'b0}}, 1'b1} << win_idx) : '0;
  end
endmodule

// File: rtl/satd_scheduler.sv
// Time-shares one SATD engine across NREQ requesters; returns tagged results and tracks the best.
module satd_scheduler import satd_pkg::*; #(
  parameter  int NREQ    = 4,
  parameter  int SATD_W  = SATD_W_DFLT,
  parameter  int TIMEOUT = 32,
  localparam int ID_W    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic              eng_start,
  output logic [ID_W-1:0]   eng_sel,
  input  logic              eng_done,
  input  logic [SATD_W-1:0] eng_satd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [SATD_W-1:0] rsp_satd,
  output logic              rsp_err,
  output logic              best_valid,
  output logic [SATD_W-1:0] best_satd,
  output logic [ID_W-1:0]   best_id,
  input  logic              clear_best,
  output logic              spurious,
  output logic              busy
);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  logic [1:0]       state;
  logic [ID_W-1:0]  rr_ptr;
  logic [TMR_W-1:0] timer;
  logic [NREQ-1:0]  arb_win;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_any;
  logic             hs;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req(req), .ptr(rr_ptr), .win(arb_win), .win_idx(arb_idx), .any(arb_any)
  );

  assign hs   = (state == ST_RESP) && rsp_ready;
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rr_ptr    <= ID_W'(NREQ - 1);
      timer     <= '0;
      gnt       <= '0;
      eng_start <= 1'b0;
      eng_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_satd  <= '0;
      rsp_err   <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      gnt       <= '0;
      eng_start <= 1'b0;
      if (eng_done && state != ST_RUN) spurious <= 1'b1;
      case (state)
        ST_IDLE: if (arb_any) begin
          state     <= ST_RUN;
          gnt       <= arb_win;
          eng_start <= 1'b1;
          eng_sel   <= arb_idx;
          rr_ptr    <= arb_idx;
          timer     <= '0;
        end
        ST_RUN: begin
          timer <= timer + TMR_W'(1);
          // A result arriving on the watchdog cycle still counts as a normal result.
          if (eng_done) begin
            rsp_satd  <= eng_satd;
            rsp_err   <= 1'b0;
            rsp_id    <= eng_sel;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timer == TMR_W'(TIMEOUT - 1)) begin
            rsp_satd  <= '1;
            rsp_err   <= 1'b1;
            rsp_id    <= eng_sel;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end
        end
        ST_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Clear takes effect before a same-cycle load, so a cleared tracker always accepts the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_valid <= 1'b0;
      best_satd  <= '0;
      best_id    <= '0;
    end else if (hs && !rsp_err && (clear_best || !best_valid || rsp_satd < best_satd)) begin
      best_valid <= 1'b1;
      best_satd  <= rsp_satd;
      best_id    <= rsp_id;
    end else if (clear_best) begin
      best_valid <= 1'b0;
      best_satd  <= '0;
      best_id    <= '0;
    end
  end
endmodule

// File: tb/tb_satd_scheduler.sv
// Bench for satd_scheduler: vector table plus hand sequences, results checked via a scoreboard queue.
module tb_satd_scheduler;
  import satd_pkg::*;
  localparam int NREQ = 4, SATD_W = 16, ID_W = 2;

  logic              clk, reset;
  logic [NREQ-1:0]   req, gnt;
  logic              eng_start, eng_done, mdl_done, spur_done;
  logic [ID_W-1:0]   eng_sel, rsp_id, best_id;
  logic [SATD_W-1:0] eng_satd, rsp_satd, best_satd;
  logic              rsp_valid, rsp_ready, rsp_err, best_valid, clear_best, spurious, busy;

  typedef struct { logic [ID_W-1:0] id; logic [SATD_W-1:0] satd; logic err; } exp_t;
  typedef struct { bit rst; logic [NREQ-1:0] rq; bit keep; int id; logic [SATD_W-1:0] satd; } vec_t;

  exp_t              sb[$];
  exp_t              last_e;
  vec_t              vt[9];
  logic [SATD_W-1:0] eng_tab[NREQ];
  int                eng_lat, eng_cnt;
  int                nvec, nerr, cyc;
  logic              bv;
  logic [SATD_W-1:0] bs;
  logic [ID_W-1:0]   bi;

  satd_scheduler #(.NREQ(NREQ), .SATD_W(SATD_W), .TIMEOUT(32)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .eng_start(eng_start), .eng_sel(eng_sel),
    .eng_done(eng_done), .eng_satd(eng_satd), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_satd(rsp_satd), .rsp_err(rsp_err), .best_valid(best_valid),
    .best_satd(best_satd), .best_id(best_id), .clear_best(clear_best), .spurious(spurious),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign eng_done = mdl_done | spur_done;

  // Engine model: answers eng_lat cycles after start with the table value of the selected pixels.
  initial begin mdl_done = 1'b0; eng_satd = '0; eng_cnt = 0; end
  always @(negedge clk) begin
    mdl_done = 1'b0;
    if (reset) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin mdl_done = 1'b1; eng_satd = eng_tab[eng_sel]; end
      end
      if (eng_start && eng_lat > 1) eng_cnt = eng_lat - 1;
    end
  end

  task automatic tick(); @(negedge clk); endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_best();
    chk("best_valid", 64'(best_valid), 64'(bv));
    chk("best_satd", 64'(best_satd), 64'(bs));
    chk("best_id", 64'(best_id), 64'(bi));
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    bv = 1'b0; bs = '0; bi = '0;
    chk("busy_after_reset", 64'(busy), 64'd0);
  endtask

  task automatic wait_gnt(input int id, input bit keep);
    for (int n = 0; n < 4; n++) begin
      tick();
      if (gnt != '0) break;
    end
    chk("gnt", 64'(gnt), 64'(1 << id));
    chk("eng_start", 64'(eng_start), 64'd1);
    chk("eng_sel", 64'(eng_sel), 64'(id));
    if (!keep) req = '0;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (rsp_valid) begin c = i; break; end
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("sb_depth", 64'(sb.size()), 64'd1);
    if (sb.size() > 0) begin
      last_e = sb.pop_front();
      chk("rsp_id", 64'(rsp_id), 64'(last_e.id));
      chk("rsp_satd", 64'(rsp_satd), 64'(last_e.satd));
      chk("rsp_err", 64'(rsp_err), 64'(last_e.err));
    end
  endtask

  // Accepts the pending response (rsp_ready must be high) and checks the best tracker afterwards.
  task automatic handshake();
    tick();
    if (clear_best) begin bv = 1'b0; bs = '0; bi = '0; end
    if (!last_e.err && (!bv || last_e.satd < bs)) begin bv = 1'b1; bs = last_e.satd; bi = last_e.id; end
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("gnt_on_hs", 64'(gnt), 64'd0);
    chk_best();
  endtask

  initial begin
    nvec = 0; nerr = 0;
    reset = 1'b1; req = '0; rsp_ready = 1'b1; clear_best = 1'b0; spur_done = 1'b0;
    eng_lat = SATD_ENG_LAT;
    for (int i = 0; i < NREQ; i++) eng_tab[i] = '0;
    bv = 1'b0; bs = '0; bi = '0;
    tick(); tick();
    chk("reset_outs", 64'({gnt, eng_start, eng_sel, rsp_valid, rsp_id, rsp_satd, rsp_err,
                           best_valid, best_satd, best_id, spurious, busy}), 64'd0);
    reset = 1'b0;

    vt[0] = '{1'b1, 4'b0001, 1'b0, 0, 16'h0123};
    vt[1] = '{1'b1, 4'b1111, 1'b1, 0, 16'h0A00};
    vt[2] = '{1'b0, 4'b1111, 1'b1, 1, 16'h0A01};
    vt[3] = '{1'b0, 4'b1111, 1'b1, 2, 16'h09FF};
    vt[4] = '{1'b0, 4'b1111, 1'b1, 3, 16'h0A03};
    vt[5] = '{1'b0, 4'b1111, 1'b0, 0, 16'h0A04};
    vt[6] = '{1'b0, 4'b1010, 1'b0, 1, 16'h0B01};
    vt[7] = '{1'b0, 4'b1001, 1'b0, 3, 16'h0005};
    vt[8] = '{1'b0, 4'b0110, 1'b0, 1, 16'h0B11};
    foreach (vt[v]) begin
      if (vt[v].rst) do_reset();
      eng_tab[vt[v].id] = vt[v].satd;
      req = vt[v].rq;
      sb.push_back('{ID_W'(vt[v].id), vt[v].satd, 1'b0});
      wait_gnt(vt[v].id, vt[v].keep);
      wait_rsp(cyc);
      chk("done_to_rsp_lat", 64'(cyc), 64'(SATD_ENG_LAT));
      handshake();
    end
    chk("spurious_clean", 64'(spurious), 64'd0);

    // Hung engine: watchdog abort, consumer stalls 5 cycles while another requester waits.
    eng_lat = 0; rsp_ready = 1'b0; req = 4'b0001;
    sb.push_back('{2'd0, 16'hFFFF, 1'b1});
    wait_gnt(0, 1'b0);
    wait_rsp(cyc);
    chk("timeout_cycle", 64'(cyc), 64'd32);
    eng_lat = SATD_ENG_LAT; eng_tab[1] = 16'h0050; req = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_hold", 64'({rsp_valid, rsp_id, rsp_satd, rsp_err}), 64'({1'b1, 2'd0, 16'hFFFF, 1'b1}));
      chk("stall_no_gnt", 64'({gnt, busy}), 64'({4'b0000, 1'b1}));
    end
    rsp_ready = 1'b1;
    handshake();

    // Best tracker: clear alone, then 0x50/0x40/0x40 with a clear on the last handshake.
    sb.push_back('{2'd1, 16'h0050, 1'b0});
    wait_gnt(1, 1'b0);
    clear_best = 1'b1; tick(); clear_best = 1'b0;
    bv = 1'b0; bs = '0; bi = '0;
    chk_best();
    wait_rsp(cyc);
    handshake();
    eng_tab[2] = 16'h0040; req = 4'b0100;
    sb.push_back('{2'd2, 16'h0040, 1'b0});
    wait_gnt(2, 1'b0);
    wait_rsp(cyc);
    handshake();
    eng_tab[3] = 16'h0040; req = 4'b1000;
    sb.push_back('{2'd3, 16'h0040, 1'b0});
    wait_gnt(3, 1'b0);
    wait_rsp(cyc);
    clear_best = 1'b1;
    handshake();
    clear_best = 1'b0;
    chk("best_after_clear_hs", 64'({best_satd, best_id}), 64'({16'h0040, 2'd3}));

    // Engine pulse with nothing running.
    spur_done = 1'b1; tick(); spur_done = 1'b0; tick();
    chk("spurious_set", 64'(spurious), 64'd1);
    chk("spurious_no_rsp", 64'({rsp_valid, busy}), 64'd0);

    // Reset in the middle of a run drops everything at once.
    req = 4'b0100;
    wait_gnt(2, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; #1;
    chk("async_reset_outs", 64'({gnt, eng_start, eng_sel, rsp_valid, rsp_id, rsp_satd, rsp_err,
                                 best_valid, best_satd, best_id, spurious, busy}), 64'd0);
    tick(); tick(); reset = 1'b0;
    bv = 1'b0; bs = '0; bi = '0;
    eng_tab[0] = 16'h0777; req = 4'b1111;
    sb.push_back('{2'd0, 16'h0777, 1'b0});
    wait_gnt(0, 1'b0);
    wait_rsp(cyc);
    handshake();
    for (int i = 0; i < 3; i++) tick();
    chk("no_late_rsp", 64'({rsp_valid, spurious}), 64'd0);
    chk("sb_left", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
